backscatter_mode_ctrl: RTL and testbench

//  Parametrised front-panel controller for the reverse-backscatter board.
//  - Debounces the two active-low buttons; BTN0 cycles the modulation mode, BTN1 toggles antenna select.
//  - Generates the complementary RFSWA/RFSWB subcarrier with break-before-make dead time and a per-mode divider.
//  - Drives EDEN and ASWSEL. Sits directly under top, between the pads and the RF switch pins.

---
 rtl/backscatter_mode_ctrl_if.sv | 23 ++
 rtl/backscatter_mode_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_backscatter_mode_ctrl.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/backscatter_mode_ctrl_if.sv
// Front-panel pin bundle for the backscatter mode controller.
//   BTN0, BTN1 : raw active-low buttons (advance mode / toggle antenna)
//   EDEN       : envelope-detector enable
//   RFSWA/B    : complementary RF switch drives
//   ASWSEL     : antenna select
//   MODE       : current mode, for status LEDs
// master = pad/board side driving buttons, slave = the controller.
interface backscatter_mode_ctrl_if #(
  parameter int MODE_W = 2
);
  logic              BTN0;
  logic              BTN1;
  logic              EDEN;
  logic              RFSWA;
  logic              RFSWB;
  logic              ASWSEL;
  logic [MODE_W-1:0] MODE;

  modport master (output BTN0, BTN1,
                  input  EDEN, RFSWA, RFSWB, ASWSEL, MODE);
  modport slave  (input  BTN0, BTN1,
                  output EDEN, RFSWA, RFSWB, ASWSEL, MODE);
endinterface

// File: rtl/backscatter_mode_ctrl.sv
// Front-panel controller for the reverse-backscatter board.
// Debounces two active-low buttons (BTN0 cycles the mode, BTN1 toggles the
// antenna), generates the RFSWA/RFSWB subcarrier with break-before-make dead
// time and a per-mode divider, and drives EDEN / ASWSEL / MODE.
// Ports:
//   CLKA   : system clock
//   RSTBTN : synchronous reset, active-high
//   pins   : button inputs and RF/status outputs (slave modport)
//
// Switch FSM states:
//   state   | meaning
//   IDLE    | mode 0, both switches off
//   A_ON    | RFSWA driven, HP-DEAD_CYC cycles
//   DEAD_AB | both off, DEAD_CYC cycles, A -> B
//   B_ON    | RFSWB driven, HP-DEAD_CYC cycles
//   DEAD_BA | both off, DEAD_CYC cycles, B -> A (also entry after a mode change)
module backscatter_mode_ctrl #(
  parameter int DEB_CYCLES = 256,
  parameter int NUM_MODES  = 4,
  parameter int DIV_BASE   = 10,
  parameter int DEAD_CYC   = 1,
  parameter int MODE_W     = 2
) (
  input logic CLKA,
  input logic RSTBTN,
  backscatter_mode_ctrl_if.slave pins
);

  localparam int DEB_W = $clog2(DEB_CYCLES + 1);
  localparam int CNT_W = MODE_W + $clog2(DIV_BASE) + NUM_MODES;

  typedef enum logic [2:0] {IDLE, A_ON, DEAD_AB, B_ON, DEAD_BA} sw_state_t;

  logic [1:0]       btn_raw;
  logic [1:0]       sync1, sync2, deb, press;
  logic [DEB_W-1:0] deb_cnt [2];

  sw_state_t         state;
  logic [MODE_W-1:0] mode, mode_nxt;
  logic [CNT_W-1:0]  cnt, hp, dur;
  logic              tc, quiet_nxt, pend, pend_eff;
  logic              eden, rfswa, rfswb, aswsel;

  assign btn_raw = {pins.BTN1, pins.BTN0};

  // press[i] is a one-cycle pulse on the debounced falling edge only.
  always_ff @(posedge CLKA) begin
    if (RSTBTN) begin
      sync1      <= '1;
      sync2      <= '1;
      deb        <= '1;
      press      <= '0;
      deb_cnt[0] <= '0;
      deb_cnt[1] <= '0;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
      press <= '0;
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == deb[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == DEB_W'(DEB_CYCLES - 1)) begin
          deb_cnt[i] <= '0;
          deb[i]     <= sync2[i];
          press[i]   <= ~sync2[i];
        end else begin
          deb_cnt[i] <= deb_cnt[i] + DEB_W'(1);
        end
      end
    end
  end

  assign mode_nxt = (mode == MODE_W'(NUM_MODES - 1)) ? '0 : mode + MODE_W'(1);
  // Half period doubles per mode; the value is meaningless in mode 0 (IDLE ignores it).
  assign hp  = CNT_W'(DIV_BASE) << (mode - MODE_W'(1));
  assign dur = (state == A_ON || state == B_ON) ? hp - CNT_W'(DEAD_CYC) : CNT_W'(DEAD_CYC);
  assign tc  = (cnt == dur - CNT_W'(1));

  // True when both switches will be off after this edge; the antenna may only
  // move on such an edge so it never changes under a conducting RF switch.
  always_comb begin
    quiet_nxt = 1'b1;
    if (!press[0]) begin
      case (state)
        IDLE:            quiet_nxt = 1'b1;
        A_ON, B_ON:      quiet_nxt = tc;
        DEAD_AB, DEAD_BA: quiet_nxt = !tc;
        default:         quiet_nxt = 1'b1;
      endcase
    end
  end

  assign pend_eff = pend | press[1];

  always_ff @(posedge CLKA) begin
    if (RSTBTN) begin
      state  <= IDLE;
      cnt    <= '0;
      mode   <= '0;
      eden   <= 1'b1;
      rfswa  <= 1'b0;
      rfswb  <= 1'b0;
      aswsel <= 1'b0;
      pend   <= 1'b0;
    end else begin
      if (pend_eff && quiet_nxt) begin
        aswsel <= ~aswsel;
        pend   <= 1'b0;
      end else begin
        pend <= pend_eff;
      end

      if (press[0]) begin
        mode  <= mode_nxt;
        eden  <= (mode_nxt == '0);
        cnt   <= '0;
        rfswa <= 1'b0;
        rfswb <= 1'b0;
        state <= (mode_nxt == '0) ? IDLE : DEAD_BA;
      end else begin
        case (state)
          IDLE: begin
            cnt   <= '0;
            rfswa <= 1'b0;
            rfswb <= 1'b0;
          end
          A_ON: begin
            if (tc) begin
              state <= DEAD_AB;
              cnt   <= '0;
              rfswa <= 1'b0;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          DEAD_AB: begin
            if (tc) begin
              state <= B_ON;
              cnt   <= '0;
              rfswb <= 1'b1;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          B_ON: begin
            if (tc) begin
              state <= DEAD_BA;
              cnt   <= '0;
              rfswb <= 1'b0;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          DEAD_BA: begin
            if (tc) begin
              state <= A_ON;
              cnt   <= '0;
              rfswa <= 1'b1;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          default: begin
            state <= IDLE;
            cnt   <= '0;
            rfswa <= 1'b0;
            rfswb <= 1'b0;
          end
        endcase
      end
    end
  end

  assign pins.EDEN   = eden;
  assign pins.RFSWA  = rfswa;
  assign pins.RFSWB  = rfswb;
  assign pins.ASWSEL = aswsel;
  assign pins.MODE   = mode;

endmodule

// File: tb/tb_backscatter_mode_ctrl.sv
module tb_backscatter_mode_ctrl;
  localparam int DEB  = 256;
  localparam int NM   = 4;
  localparam int DIVB = 10;
  localparam int DEAD = 1;
  localparam int MW   = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #25 clk = ~clk;

  backscatter_mode_ctrl_if #(.MODE_W(MW)) pins();

  backscatter_mode_ctrl #(
    .DEB_CYCLES(DEB), .NUM_MODES(NM), .DIV_BASE(DIVB), .DEAD_CYC(DEAD), .MODE_W(MW)
  ) dut (
    .CLKA(clk),
    .RSTBTN(rst),
    .pins(pins)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int ecyc; logic [5:0] vec; } ev_t;
  typedef struct { int ecyc; int kind; } plan_t;   // kind: 0 btn0, 1 btn1, 2 reset
  ev_t   sb[$];
  plan_t plan[$];

  int n_checks = 0;
  int n_fail   = 0;
  bit model_on = 1'b0;
  bit mon_on   = 1'b0;

  int         m_mode = 0;
  int         m_e0   = 0;
  bit         m_pend = 1'b0;
  bit         m_asw  = 1'b0;
  logic [5:0] m_last = 6'b001000;
  logic [5:0] prev   = 6'b001000;

  // Closed-form reference: output after edge e from the mode-change edge e0.
  task automatic model_step(input int e);
    int hp, kk, p, i;
    bit a, b;
    logic [5:0] v;
    i = 0;
    while (i < plan.size()) begin
      if (plan[i].ecyc == e) begin
        case (plan[i].kind)
          0: begin m_mode = (m_mode == NM - 1) ? 0 : m_mode + 1; m_e0 = e; end
          1: m_pend = 1'b1;
          default: begin m_mode = 0; m_pend = 1'b0; m_asw = 1'b0; end
        endcase
        plan.delete(i);
      end else begin
        i++;
      end
    end
    a = 1'b0;
    b = 1'b0;
    if (m_mode != 0) begin
      hp = DIVB << (m_mode - 1);
      kk = e - m_e0 - DEAD;
      if (kk >= 0) begin
        p = kk % (2 * hp);
        a = (p < hp - DEAD);
        b = (p >= hp) && (p < 2 * hp - DEAD);
      end
    end
    if (m_pend && !a && !b) begin
      m_asw  = ~m_asw;
      m_pend = 1'b0;
    end
    v = {2'(m_mode), (m_mode == 0), m_asw, a, b};
    if (v !== m_last) begin
      sb.push_back('{e, v});
      m_last = v;
    end
  endtask

  always @(posedge clk) begin
    if (model_on) begin
      #1;
      model_step(cyc);
    end
  end

  // Monitor: every output change must match the next expected event.
  always @(negedge clk) begin
    logic [5:0] cur;
    ev_t ev;
    if (mon_on) begin
      cur = {pins.MODE, pins.EDEN, pins.ASWSEL, pins.RFSWA, pins.RFSWB};
      n_checks++;
      if (pins.RFSWA === 1'b1 && pins.RFSWB === 1'b1) begin
        n_fail++;
        $display("FAIL overlap: RFSWA and RFSWB both high at edge %0d", cyc);
      end
      if (cur !== prev) begin
        n_checks++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_change: at edge %0d got %b, none expected (was %b)", cyc, cur, prev);
        end else begin
          ev = sb.pop_front();
          if (ev.ecyc != cyc || ev.vec !== cur) begin
            n_fail++;
            $display("FAIL event: at edge %0d got %b, expected %b at edge %0d", cyc, cur, ev.vec, ev.ecyc);
          end
        end
        prev = cur;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (edge %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_to(input int e);
    while (cyc < e) step(1);
  endtask

  task automatic press(input bit b0, input bit b1, input int hold, output int ce);
    ce = cyc + DEB + 3;
    if (b0) plan.push_back('{ce, 0});
    if (b1) plan.push_back('{ce, 1});
    if (b0) pins.BTN0 = 1'b0;
    if (b1) pins.BTN1 = 1'b0;
    step(hold);
    pins.BTN0 = 1'b1;
    pins.BTN1 = 1'b1;
    step(300);
  endtask

  initial begin
    int c, c1, c2, n, p1, td, k, r;
    pins.BTN0 = 1'b1;
    pins.BTN1 = 1'b1;
    rst = 1'b1;

    // T1: reset values
    step(10);
    chk("rst_mode", pins.MODE, 0);
    chk("rst_eden", pins.EDEN, 1);
    chk("rst_rfswa", pins.RFSWA, 0);
    chk("rst_rfswb", pins.RFSWB, 0);
    chk("rst_aswsel", pins.ASWSEL, 0);
    rst = 1'b0;
    model_on = 1'b1;
    mon_on   = 1'b1;
    step(2000);

    // T2: glitch shorter than the debounce window
    pins.BTN0 = 1'b0;
    step(100);
    pins.BTN0 = 1'b1;
    step(400);
    chk("glitch_mode", pins.MODE, 0);

    // T3: long press -> mode 1
    press(1'b1, 1'b0, 1000, c);
    chk("t3_mode", pins.MODE, 1);
    chk("t3_eden", pins.EDEN, 0);

    // T4: modes 2, 3, then wrap to 0
    press(1'b1, 1'b0, 300, c);
    chk("t4_mode2", pins.MODE, 2);
    press(1'b1, 1'b0, 300, c);
    chk("t4_mode3", pins.MODE, 3);
    press(1'b1, 1'b0, 300, c);
    chk("t4_mode0", pins.MODE, 0);
    chk("t4_eden", pins.EDEN, 1);
    chk("t4_sw", {pins.RFSWA, pins.RFSWB}, 0);

    // T5a: antenna toggle in mode 0
    press(1'b0, 1'b1, 300, c);
    chk("t5_asw_idle", pins.ASWSEL, 1);

    // T5b/c: mode 1, antenna press landing inside A_ON
    press(1'b1, 1'b0, 300, c1);
    n  = ((cyc + 1 + DEB + 3) - (c1 + DEAD + 3) + 19) / 20;
    p1 = c1 + DEAD + 20 * n + 3;
    td = c1 + DEAD + 20 * n + 9;
    k  = p1 - DEB - 3;
    wait_to(k);
    plan.push_back('{p1, 1});
    pins.BTN1 = 1'b0;
    wait_to(p1);
    chk("t5_asw_pending", pins.ASWSEL, 1);
    wait_to(td - 1);
    chk("t5_asw_a_on", {pins.ASWSEL, pins.RFSWA}, 2'b11);
    wait_to(td);
    chk("t5_asw_dead_ab", {pins.ASWSEL, pins.RFSWA}, 2'b00);
    wait_to(k + 300);
    pins.BTN1 = 1'b1;
    step(300);

    // Simultaneous BTN0 + BTN1
    press(1'b1, 1'b1, 300, c2);
    chk("sim_mode", pins.MODE, 2);
    chk("sim_asw", pins.ASWSEL, 1);

    // T6: reset during B_ON with BTN0 held
    n = ((cyc + 11) - (c2 + 26) + 39) / 40;
    r = c2 + 1 + 40 * n + 25;
    wait_to(r - 10);
    pins.BTN0 = 1'b0;
    wait_to(r - 1);
    chk("t6_b_on", {pins.RFSWA, pins.RFSWB}, 2'b01);
    plan.push_back('{r, 2});
    plan.push_back('{r + DEB + 3, 0});
    rst = 1'b1;
    wait_to(r);
    rst = 1'b0;
    chk("t6_rst_vec", {pins.MODE, pins.EDEN, pins.ASWSEL, pins.RFSWA, pins.RFSWB}, 6'b001000);
    wait_to(r + DEB + 2);
    chk("t6_mode_before", pins.MODE, 0);
    wait_to(r + DEB + 3);
    chk("t6_mode_after", pins.MODE, 1);
    wait_to(r + 500);
    pins.BTN0 = 1'b1;
    step(300);
    chk("t6_single_press", pins.MODE, 1);

    step(5);
    model_on = 1'b0;
    @(negedge clk);
    #1;
    mon_on = 1'b0;
    chk("sb_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
